// File: rtl/dmem_responder.sv
// Data-side responder with one outstanding access and WAIT_CYCLES wait states, serving loads and stores from a word RAM.
// Latency: accept at edge k, response at k+1+WAIT_CYCLES; rsp_ready low holds RESP and every response output indefinitely.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  fault;
  logic                  access;
  logic                  wr_en;

  assign idx    = addr_q[ADDR_WIDTH+1:2];
  assign fault  = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);
  assign access = (state_q == WAIT) && (cnt_q == 4'd0);
  assign wr_en  = access && we_q && !fault;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          // Stores and faulted accesses both report zero data; only a clean load reads the RAM.
          if (fault) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end else if (we_q) begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
          end else begin
            rdata_d = mem[idx];
            err_d   = 1'b0;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM is deliberately not reset; writes are gated by the state register, which reset clears.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side bus responder for the single-cycle core's load/store path. It accepts one load or store request at a time over a valid/ready request channel and serves it from an internal word-organised RAM after a fixed, parameterised number of wait states. It returns read data and an error flag over a valid/ready response channel. It lets the core and its testbenches exercise multi-cycle memory latency, backpressure and access faults that the zero-latency data memory cannot model.

## Interface
- ADDR_WIDTH, 10: word-address bits; RAM depth is 2^ADDR_WIDTH words of 32 bits, covering byte addresses 0 .. 4*2^ADDR_WIDTH-1.
- WAIT_CYCLES, 2: wait states inserted between request acceptance and memory access; legal range 0..15.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  store byte enables; bit i writes req_wdata[8i+7:8i]; ignored for loads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and faulted accesses.
- rsp_err  output  1  access fault (misaligned or out of range).

## Operation
- FSM states: IDLE, WAIT, RESP. Only one transaction is outstanding at a time.
- IDLE: req_ready = 1.
  - A request is accepted on an edge where req_valid & req_ready.
  - On acceptance: req_we, req_addr, req_wdata and req_be are latched; cnt <= WAIT_CYCLES; state <= WAIT.
- WAIT: req_ready = 0.
  - If cnt != 0: cnt <= cnt - 1.
  - If cnt == 0: the access is performed on this edge and state <= RESP.
- Fault check, applied to the latched address: the access faults if addr[1:0] != 0 or addr[31:ADDR_WIDTH+2] != 0.
  - On a fault, the RAM is untouched, rsp_err <= 1 and rsp_rdata <= 0.
- Access rules when no fault:
  - Load: rsp_rdata <= mem[addr[ADDR_WIDTH+1:2]], rsp_err <= 0.
  - Store: each byte lane with be set is written; rsp_rdata <= 0, rsp_err <= 0.
  - A store with be = 0 changes nothing and is not a fault.
- RESP: rsp_valid = 1.
  - rsp_rdata and rsp_err stay stable until an edge where rsp_ready = 1.
  - On that edge: state <= IDLE, rsp_valid drops, and rsp_rdata/rsp_err hold their last values.
- RAM contents are not reset; a read of a never-written in-range location returns undefined data.
- req_ready and rsp_valid are decoded from the state register only, with no combinational path from any input.

## Timing
- Reset values: state IDLE, cnt 0, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0.
- While rst = 0, no request is accepted and no RAM write occurs.
- Latency:
  - Request accepted on edge k; access and rsp_valid rise on edge k+1+WAIT_CYCLES.
  - With WAIT_CYCLES = 0, rsp_valid is high in the cycle after acceptance.
- Response handshake on edge k+2+WAIT_CYCLES at the earliest.
- req_ready is high again after that edge, so the next acceptance is at k+3+WAIT_CYCLES.
- Minimum period: WAIT_CYCLES+3 cycles per transaction.
- Backpressure: rsp_ready may stay low indefinitely; the responder holds RESP and all response outputs.
- req_valid asserted outside IDLE is ignored; the request is not queued, and the initiator must hold it until req_ready.
- Reset mid-operation:
  - The pending transaction is dropped and all outputs take their reset values immediately.
  - A store still in WAIT is never written.
  - A store already performed (RESP reached) remains in RAM.

## Test plan
- WAIT_CYCLES=2: store 0xDEADBEEF, be=4'hF to 0x10, then load 0x10. Required: rsp_valid rises 3 cycles after each acceptance, and the load returns 0xDEADBEEF with err=0.
- Partial store: store 0x11223344, be=4'b0101 over 0xDEADBEEF at 0x10, then load 0x10. Required: the load returns 0xDE22BE44.
- Faults: a load of 0x12 and a load of 4*2^ADDR_WIDTH each return err=1, rdata=0. A faulted store of 0x0 to 0x4002 (ADDR_WIDTH=10) leaves every location unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid. Required: rsp_valid, rsp_rdata and rsp_err are stable, req_ready=0, and no new request is accepted. The handshake completes on the first edge with rsp_ready=1.
- Reset: drop rst during WAIT of a store of 0xA5A5A5A5 to 0x20, after first writing 0x0 there. Required: outputs reset asynchronously, and after release a load of 0x20 returns 0x0.
- WAIT_CYCLES=0, back-to-back requests with rsp_ready tied high: acceptances occur every 3 cycles.
